// File: rtl/btb_pkg.sv
// Shared types for the set-associative branch target buffer.
package btb_pkg;

`include "sys_defs.svh"

  localparam int XLEN = `XLEN;

  // One BTB way. The tag is kept at full XLEN width, holding pc >> (IDX+2)
  // zero-extended, so the struct does not depend on the set count.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  // Flush walk controller states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } btb_state_t;

endpackage

// File: rtl/btb_lru.sv
// True-LRU age update for one set: the accessed way becomes age 0 and
// every way younger than it ages by one; older ways keep their age.
module btb_lru #(
  parameter int  WAYS = 2,
  localparam int AW   = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] age_in,
  input  logic [AW-1:0]           way,
  output logic [WAYS-1:0][AW-1:0] age_out
);

  // Ages stay a permutation of 0..WAYS-1 because only younger ways move up.
  always_comb begin
    age_out = age_in;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == way) begin
        age_out[w] = '0;
      end else if (age_in[w] < age_in[way]) begin
        age_out[w] = age_in[w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_defs.svh
// System-wide defines shared by the BTB slice.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define XLEN 32

`endif

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with registered lookup, true-LRU
// replacement, single-entry invalidation and a one-set-per-cycle flush walk.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            write_enable,
  input  logic [XLEN-1:0] write_source_pc,
  input  logic [XLEN-1:0] write_dest_pc,
  input  logic            inval_enable,
  input  logic [XLEN-1:0] inval_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] query_pc,
  output logic            hit,
  output logic [XLEN-1:0] target_pc,
  output logic            busy
);

  localparam int IDX = $clog2(SETS);
  localparam int AW  = $clog2(WAYS);

  typedef logic [WAYS-1:0][AW-1:0] age_vec_t;

  btb_entry_t     entries [SETS][WAYS];
  age_vec_t       ages    [SETS];
  btb_state_t     state;
  logic [IDX-1:0] cnt;

  logic [IDX-1:0]  q_idx, w_idx, i_idx;
  logic [XLEN-1:0] q_tag, w_tag, i_tag;

  logic [WAYS-1:0] q_match;
  logic [AW-1:0]   q_way;
  logic            w_found, w_free;
  logic [AW-1:0]   w_match_way, w_free_way, victim, w_way;
  logic            i_found;
  logic [AW-1:0]   i_way;

  logic            accept, q_upd, do_inval, do_write, same_target;
  age_vec_t        q_age_new, w_age_base, w_age_new;

  assign q_idx = query_pc[IDX+1:2];
  assign w_idx = write_source_pc[IDX+1:2];
  assign i_idx = inval_pc[IDX+1:2];
  assign q_tag = query_pc >> (IDX + 2);
  assign w_tag = write_source_pc >> (IDX + 2);
  assign i_tag = inval_pc >> (IDX + 2);

  // Query tag compare against the pre-update array; hit needs exactly one match.
  always_comb begin
    q_match = '0;
    q_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (entries[q_idx][w].valid && (entries[q_idx][w].tag == q_tag)) begin
        q_match[w] = 1'b1;
        q_way      = AW'(w);
      end
    end
  end

  // Write-side lookup: matching way for in-place update, lowest invalid way for allocation.
  always_comb begin
    w_found     = 1'b0;
    w_match_way = '0;
    w_free      = 1'b0;
    w_free_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (entries[w_idx][w].valid && (entries[w_idx][w].tag == w_tag)) begin
        w_found     = 1'b1;
        w_match_way = AW'(w);
      end
      if (!entries[w_idx][w].valid) begin
        w_free     = 1'b1;
        w_free_way = AW'(w);
      end
    end
  end

  // Invalidation lookup.
  always_comb begin
    i_found = 1'b0;
    i_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (entries[i_idx][w].valid && (entries[i_idx][w].tag == i_tag)) begin
        i_found = 1'b1;
        i_way   = AW'(w);
      end
    end
  end

  // Flush outranks invalidation, which outranks a write to the same entry.
  assign busy        = (state == ST_FLUSH);
  assign accept      = !busy && !flush;
  assign q_upd       = accept && $onehot(q_match);
  assign do_inval    = accept && inval_enable && i_found;
  assign same_target = inval_enable && (i_idx == w_idx) && (i_tag == w_tag);
  assign do_write    = accept && write_enable && !same_target;

  btb_lru #(.WAYS(WAYS)) u_lru_query (
    .age_in  (ages[q_idx]),
    .way     (q_way),
    .age_out (q_age_new)
  );

  // A same-cycle query hit in the write's set counts as the older access.
  assign w_age_base = (q_upd && (q_idx == w_idx)) ? q_age_new : ages[w_idx];

  // Victim is the oldest way, the one holding age WAYS-1.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_age_base[w] == AW'(WAYS - 1)) begin
        victim = AW'(w);
      end
    end
  end

  assign w_way = w_found ? w_match_way : (w_free ? w_free_way : victim);

  btb_lru #(.WAYS(WAYS)) u_lru_write (
    .age_in  (w_age_base),
    .way     (w_way),
    .age_out (w_age_new)
  );

  // Array and age storage: flush walk clears a set, otherwise apply hit/inval/write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          entries[s][w] <= '0;
          ages[s][w]    <= AW'(w);
        end
      end
    end else if (busy) begin
      for (int w = 0; w < WAYS; w++) begin
        entries[cnt][w].valid <= 1'b0;
      end
    end else begin
      if (q_upd) begin
        ages[q_idx] <= q_age_new;
      end
      if (do_inval) begin
        entries[i_idx][i_way].valid <= 1'b0;
      end
      if (do_write) begin
        entries[w_idx][w_way].valid  <= 1'b1;
        entries[w_idx][w_way].tag    <= w_tag;
        entries[w_idx][w_way].target <= write_dest_pc;
        ages[w_idx]                  <= w_age_new;
      end
    end
  end

  // Flush walk controller: one set per cycle, back to idle after the last set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX'(SETS - 1)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered lookup result, zero target on miss.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit       <= 1'b0;
      target_pc <= '0;
    end else begin
      hit       <= q_upd;
      target_pc <= q_upd ? entries[q_idx][q_way].target : '0;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (SETS=16, WAYS=2, XLEN=32).
module tb_btb_assoc;
  import btb_pkg::*;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            write_enable = 1'b0;
  logic [XLEN-1:0] write_source_pc = '0;
  logic [XLEN-1:0] write_dest_pc = '0;
  logic            inval_enable = 1'b0;
  logic [XLEN-1:0] inval_pc = '0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] query_pc = '0;
  logic            hit;
  logic [XLEN-1:0] target_pc;
  logic            busy;

  int n_compared = 0;
  int n_mismatch = 0;

  typedef struct {
    logic            hit;
    logic [XLEN-1:0] target;
  } exp_t;

  typedef struct {
    logic            we;
    logic [XLEN-1:0] wpc;
    logic [XLEN-1:0] wdst;
    logic            ie;
    logic [XLEN-1:0] ipc;
    logic            fl;
    logic            qv;
    logic [XLEN-1:0] qpc;
    logic            eh;
    logic [XLEN-1:0] et;
  } op_t;

  exp_t sb[$];

  btb_assoc #(.SETS(16), .WAYS(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .write_enable    (write_enable),
    .write_source_pc (write_source_pc),
    .write_dest_pc   (write_dest_pc),
    .inval_enable    (inval_enable),
    .inval_pc        (inval_pc),
    .flush           (flush),
    .query_pc        (query_pc),
    .hit             (hit),
    .target_pc       (target_pc),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic op_t mk(logic we, logic [XLEN-1:0] wpc, logic [XLEN-1:0] wdst,
                             logic ie, logic [XLEN-1:0] ipc, logic fl, logic qv,
                             logic [XLEN-1:0] qpc, logic eh, logic [XLEN-1:0] et);
    op_t o;
    o.we = we; o.wpc = wpc; o.wdst = wdst;
    o.ie = ie; o.ipc = ipc; o.fl = fl;
    o.qv = qv; o.qpc = qpc; o.eh = eh; o.et = et;
    return o;
  endfunction

  function automatic op_t op_w(logic [XLEN-1:0] pc, logic [XLEN-1:0] dst);
    return mk(1'b1, pc, dst, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endfunction

  function automatic op_t op_q(logic [XLEN-1:0] pc, logic h, logic [XLEN-1:0] t);
    return mk(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, pc, h, t);
  endfunction

  function automatic op_t op_i(logic [XLEN-1:0] pc);
    return mk(1'b0, '0, '0, 1'b1, pc, 1'b0, 1'b0, '0, 1'b0, '0);
  endfunction

  function automatic op_t op_f();
    return mk(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
  endfunction

  function automatic op_t op_nop();
    return mk(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endfunction

  // Drive one cycle of stimulus; a checked query pushes its expected result.
  task automatic drive(input op_t o);
    write_enable    = o.we;
    write_source_pc = o.wpc;
    write_dest_pc   = o.wdst;
    inval_enable    = o.ie;
    inval_pc        = o.ipc;
    flush           = o.fl;
    query_pc        = o.qpc;
    if (o.qv) sb.push_back('{hit: o.eh, target: o.et});
    @(posedge clock);
    #1;
    write_enable = 1'b0;
    inval_enable = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #3;
    @(posedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    n_compared++;
    if (hit !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_hit: got %0b want 0", hit);
    end
    n_compared++;
    if (target_pc !== '0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_target: got %h want 0", target_pc);
    end
    n_compared++;
    if (busy !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_busy: got %0b want 0", busy);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    drive(op_q(32'h100, 1'b0, 32'h0));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_compared++;
      if (hit !== e.hit || target_pc !== e.target) begin
        n_mismatch++;
        $display("[TB] FAIL reset_query: hit=%0b target=%h want hit=%0b target=%h",
                 hit, target_pc, e.hit, e.target);
      end
    end
  endtask

  task automatic test_write();
    op_t  ops[$];
    exp_t e;
    apply_reset();
    ops.push_back(mk(1'b1, 32'h100, 32'h200, 1'b0, '0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0));
    ops.push_back(op_q(32'h100, 1'b1, 32'h200));
    ops.push_back(op_q(32'h102, 1'b1, 32'h200));
    ops.push_back(op_q(32'h104, 1'b0, 32'h0));
    ops.push_back(op_q(32'h140, 1'b0, 32'h0));
    for (int i = 0; i < ops.size(); i++) begin
      drive(ops[i]);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_compared++;
        if (hit !== e.hit || target_pc !== e.target) begin
          n_mismatch++;
          $display("[TB] FAIL write step %0d: hit=%0b target=%h want hit=%0b target=%h",
                   i, hit, target_pc, e.hit, e.target);
        end
      end
    end
  endtask

  task automatic test_lru();
    op_t  ops[$];
    exp_t e;
    apply_reset();
    ops.push_back(op_w(32'h100, 32'hA00));
    ops.push_back(op_w(32'h140, 32'hA40));
    ops.push_back(op_q(32'h100, 1'b1, 32'hA00));
    ops.push_back(op_w(32'h180, 32'hA80));
    ops.push_back(op_q(32'h140, 1'b0, 32'h0));
    ops.push_back(op_q(32'h100, 1'b1, 32'hA00));
    ops.push_back(op_q(32'h180, 1'b1, 32'hA80));
    ops.push_back(op_w(32'h140, 32'hB40));
    ops.push_back(op_q(32'h100, 1'b0, 32'h0));
    ops.push_back(op_q(32'h180, 1'b1, 32'hA80));
    ops.push_back(op_q(32'h140, 1'b1, 32'hB40));
    for (int i = 0; i < ops.size(); i++) begin
      drive(ops[i]);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_compared++;
        if (hit !== e.hit || target_pc !== e.target) begin
          n_mismatch++;
          $display("[TB] FAIL lru step %0d: hit=%0b target=%h want hit=%0b target=%h",
                   i, hit, target_pc, e.hit, e.target);
        end
      end
    end
  endtask

  task automatic test_update_inval();
    op_t  ops[$];
    exp_t e;
    apply_reset();
    ops.push_back(op_w(32'h140, 32'h540));
    ops.push_back(op_w(32'h100, 32'h200));
    ops.push_back(op_w(32'h100, 32'h300));
    ops.push_back(op_q(32'h100, 1'b1, 32'h300));
    ops.push_back(op_q(32'h140, 1'b1, 32'h540));
    ops.push_back(op_i(32'h100));
    ops.push_back(op_q(32'h100, 1'b0, 32'h0));
    ops.push_back(op_q(32'h140, 1'b1, 32'h540));
    ops.push_back(op_i(32'h180));
    ops.push_back(op_q(32'h140, 1'b1, 32'h540));
    ops.push_back(mk(1'b1, 32'h140, 32'h777, 1'b1, 32'h140, 1'b0, 1'b0, '0, 1'b0, '0));
    ops.push_back(op_q(32'h140, 1'b0, 32'h0));
    for (int i = 0; i < ops.size(); i++) begin
      drive(ops[i]);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_compared++;
        if (hit !== e.hit || target_pc !== e.target) begin
          n_mismatch++;
          $display("[TB] FAIL update_inval step %0d: hit=%0b target=%h want hit=%0b target=%h",
                   i, hit, target_pc, e.hit, e.target);
        end
      end
    end
  endtask

  task automatic test_flush();
    op_t  ops[$];
    op_t  post[$];
    exp_t e;
    int   busy_cycles;
    apply_reset();
    ops.push_back(op_w(32'h100, 32'h200));
    ops.push_back(op_w(32'h140, 32'h240));
    ops.push_back(op_w(32'h104, 32'h204));
    ops.push_back(op_w(32'h03C, 32'h23C));
    ops.push_back(op_q(32'h03C, 1'b1, 32'h23C));
    ops.push_back(op_q(32'h104, 1'b1, 32'h204));
    for (int i = 0; i < ops.size(); i++) begin
      drive(ops[i]);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_compared++;
        if (hit !== e.hit || target_pc !== e.target) begin
          n_mismatch++;
          $display("[TB] FAIL flush_load step %0d: hit=%0b target=%h want hit=%0b target=%h",
                   i, hit, target_pc, e.hit, e.target);
        end
      end
    end
    drive(op_f());
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      drive(mk(1'b1, 32'h180, 32'h280, 1'b1, 32'h140, busy_cycles == 5,
               1'b1, 32'h03C, 1'b0, 32'h0));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_compared++;
        if (hit !== e.hit || target_pc !== e.target) begin
          n_mismatch++;
          $display("[TB] FAIL flush_busy_query cycle %0d: hit=%0b target=%h want hit=%0b target=%h",
                   busy_cycles, hit, target_pc, e.hit, e.target);
        end
      end
    end
    n_compared++;
    if (busy_cycles != 16) begin
      n_mismatch++;
      $display("[TB] FAIL flush_busy_len: got %0d cycles want 16", busy_cycles);
    end
    post.push_back(op_q(32'h100, 1'b0, 32'h0));
    post.push_back(op_q(32'h140, 1'b0, 32'h0));
    post.push_back(op_q(32'h104, 1'b0, 32'h0));
    post.push_back(op_q(32'h03C, 1'b0, 32'h0));
    post.push_back(op_q(32'h180, 1'b0, 32'h0));
    for (int i = 0; i < post.size(); i++) begin
      drive(post[i]);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_compared++;
        if (hit !== e.hit || target_pc !== e.target) begin
          n_mismatch++;
          $display("[TB] FAIL flush_after step %0d: hit=%0b target=%h want hit=%0b target=%h",
                   i, hit, target_pc, e.hit, e.target);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    op_t  ops[$];
    exp_t e;
    int   busy_cycles;
    apply_reset();
    drive(op_w(32'h100, 32'h200));
    drive(op_q(32'h100, 1'b1, 32'h200));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_compared++;
      if (hit !== e.hit || target_pc !== e.target) begin
        n_mismatch++;
        $display("[TB] FAIL midreset_preload: hit=%0b target=%h want hit=%0b target=%h",
                 hit, target_pc, e.hit, e.target);
      end
    end
    reset = 1'b0;
    #2;
    n_compared++;
    if (hit !== 1'b0 || target_pc !== '0) begin
      n_mismatch++;
      $display("[TB] FAIL midreset_async_hit: hit=%0b target=%h want hit=0 target=0", hit, target_pc);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    drive(op_w(32'h100, 32'h200));
    drive(op_f());
    drive(op_nop());
    drive(op_nop());
    n_compared++;
    if (busy !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL midreset_busy_before: got %0b want 1", busy);
    end
    reset = 1'b0;
    #2;
    n_compared++;
    if (busy !== 1'b0 || hit !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL midreset_async_busy: busy=%0b hit=%0b want busy=0 hit=0", busy, hit);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    ops.push_back(op_w(32'h140, 32'h440));
    ops.push_back(op_q(32'h140, 1'b1, 32'h440));
    ops.push_back(op_q(32'h100, 1'b0, 32'h0));
    for (int i = 0; i < ops.size(); i++) begin
      drive(ops[i]);
      n_compared++;
      if (busy !== 1'b0) begin
        n_mismatch++;
        $display("[TB] FAIL midreset_idle step %0d: busy=%0b want 0", i, busy);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_compared++;
        if (hit !== e.hit || target_pc !== e.target) begin
          n_mismatch++;
          $display("[TB] FAIL midreset_after step %0d: hit=%0b target=%h want hit=%0b target=%h",
                   i, hit, target_pc, e.hit, e.target);
        end
      end
    end
    drive(op_f());
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      drive(op_nop());
    end
    n_compared++;
    if (busy_cycles != 16) begin
      n_mismatch++;
      $display("[TB] FAIL midreset_reflush_len: got %0d cycles want 16", busy_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_lru();
    test_update_inval();
    test_flush();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter SETS, 16, number of sets; power of two, >= 2.
REQ-002 SHALL have parameter WAYS, 2, entries per set; power of two, >= 2.
REQ-003 SHALL have the following ports:
  clock  input  1  system clock; all state updates on the rising edge.
  reset  input  1  asynchronous, active-low reset.
  write_enable  input  1  install or update a branch mapping this cycle.
  write_source_pc  input  XLEN  PC of the taken branch.
  write_dest_pc  input  XLEN  branch target to store.
  inval_enable  input  1  invalidate the entry matching inval_pc.
  inval_pc  input  XLEN  PC to invalidate.
  flush  input  1  start invalidation of the whole buffer.
  query_pc  input  XLEN  PC being fetched.
  hit  output  1  registered; target_pc is valid.
  target_pc  output  XLEN  registered predicted target; 0 when hit=0.
  busy  output  1  high while a flush walk is in progress.

Function
REQ-004 SHALL form index = pc[IDX+1:2] with IDX = log2(SETS), and tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
REQ-005 SHALL look up query_pc in cycle N against array state before any cycle-N update, and present hit/target_pc from cycle N+1 (one-cycle latency, no bypass).
REQ-006 SHALL drive hit=1 and the stored target when exactly one valid way in the set matches the tag; otherwise hit=0 and target_pc=0.
REQ-007 SHALL, on write with a tag match, overwrite that way's target in place, leaving other ways untouched.
REQ-008 SHALL, on write without a tag match, allocate the lowest-numbered invalid way; if none is invalid, replace the LRU way.
REQ-009 SHALL keep true LRU per set as per-way age counters of log2(WAYS) bits; the accessed way becomes age 0; ways younger than it increment.
REQ-010 SHALL update LRU on writes and on query hits only; misses and invalidations leave ages unchanged.
REQ-011 SHALL, on inval_enable with a tag match, clear that way's valid bit next edge; no match is a no-op.
REQ-012 SHALL prioritise same-cycle events: flush > inval > write; inval and write to the same set and tag leaves the entry invalid.
REQ-013 SHALL implement a two-state FSM: IDLE -> FLUSH when flush=1; in FLUSH, clear all valid bits of set[cnt] and increment cnt each cycle; FLUSH -> IDLE after set SETS-1.
REQ-014 SHALL assert busy for exactly SETS cycles per flush; flush asserted while busy is ignored.
REQ-015 SHALL, while busy, ignore write_enable and inval_enable and return hit=0 for all queries.
REQ-016 SHALL wrap cnt from SETS-1 to 0 on flush completion.

Reset
REQ-017 SHALL, while reset=0, asynchronously clear all valid bits, set each way's age to its way number, set FSM to IDLE, cnt=0, and drive hit=0, target_pc=0, busy=0.
REQ-018 SHALL abort an in-progress flush on reset, with no residual state.

Structure
REQ-019 SHALL place the entry typedef (valid, tag, target) and the FSM state enum in shared package btb_pkg; XLEN stays in sys_defs.svh.
REQ-020 SHALL implement per-set age update in one sub-module, btb_lru, parametrised by WAYS.

Verification
Bench parameters: SETS=16, WAYS=2, XLEN=32; index 0 covers 0x100, 0x140, 0x180.
REQ-021 SHALL check reset release, then query 0x100: hit=0 and target_pc=0 on the next cycle.
REQ-022 SHALL check write 0x100->0x200, then query 0x100 a cycle later: hit=1, target_pc=0x200 on the following cycle; a same-cycle query misses.
REQ-023 SHALL check LRU: write 0x100, write 0x140, query 0x100 (hit), write 0x180 -> 0x140 misses; 0x100 and 0x180 hit.
REQ-024 SHALL check update and invalidate: write 0x100->0x200 then 0x100->0x300 -> target 0x300 with 0x140 still hit; inval 0x100 -> 0x100 misses.
REQ-025 SHALL check flush with 4 entries loaded: busy=1 for exactly 16 cycles, queries and writes during busy give misses/no effect, all entries miss afterwards.
REQ-026 SHALL check reset=0 pulsed mid-flush: busy and hit drop to 0 immediately without a clock edge; a write after release installs normally.
